// File: rtl/adder_serial_ctrl.sv
// Serial WIDTH-bit add/subtract sequencer.
// Feeds one nibble per clock, LSB first, through a shared 4-bit
// ripple-carry adder slice. The inter-nibble carry lives in a register.
// Operands come in on a valid/ready request port, and the result goes out
// on a valid/ready response port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; start_ready=1
// RUN   | stepping the slice one nibble per cycle; Sum fills from the top
// DONE  | result held stable with done_valid=1 until done_ready

// 4-bit ripple-carry adder slice; the shared bus adder this block drives.
module adder_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  // Bit-by-bit ripple of the carry through the four full adders.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    co = c[4];
  end

endmodule

module adder_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("adder_serial_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;

  logic [3:0]       slice_s;
  logic             slice_co;
  logic             last_step;

  // The slice always works on the current low nibble of the operand shifters.
  adder_slice4 u_slice (
    .a  (opa_q[3:0]),
    .b  (opb_q[3:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  assign last_step = (cnt_q == CW'(NIB - 1));

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    v_d     = v_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          opa_d   = A;
          // Subtract is add of the one's complement with a forced carry-in.
          opb_d   = Sub ? ~B : B;
          carry_d = Sub ? 1'b1 : Cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        sum_d   = {slice_s, sum_q[WIDTH-1:4]};
        opa_d   = opa_q >> 4;
        opb_d   = opb_q >> 4;
        carry_d = slice_co;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          // The final nibble carries the sign bits; overflow is judged there.
          cout_d  = slice_co;
          v_d     = (opa_q[3] == opb_q[3]) && (slice_s[3] != opa_q[3]);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (done_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done_valid  = (state_q == S_DONE);
  assign Sum         = sum_q;
  assign Cout        = cout_q;
  assign V           = v_q;

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Bench for adder_serial_ctrl (WIDTH=16): directed corner cases plus random
// operations, checked against a signed/unsigned integer arithmetic model.
module tb_adder_serial_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin_in = 1'b0;
  logic         sub_in = 1'b0;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         v_o;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_serial_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .A           (a_in),
    .B           (b_in),
    .Cin         (cin_in),
    .Sub         (sub_in),
    .Sum         (sum_o),
    .Cout        (cout_o),
    .V           (v_o),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on plain integers: unsigned carry/borrow, signed range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       output logic [W-1:0] s, output logic co, output logic ov);
    longint ua, ub, ures;
    longint sa, sb, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (64'sd1 << W) : ua;
    sb = b[W-1] ? ub - (64'sd1 << W) : ub;
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(cin);
      sres = sa + sb + longint'(cin);
      co   = (ures >= (64'sd1 << W));
    end
    s  = ures[W-1:0];
    ov = (sres > ((64'sd1 << (W-1)) - 1)) || (sres < -(64'sd1 << (W-1)));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!start_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("idle_wait", {31'd0, start_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [W-1:0] es;
    logic         ec, ev;
    int           lat;
    model(a, b, cin, sub, es, ec, ev);
    wait_idle();
    @(negedge clk);
    start_valid = 1'b1;
    a_in = a; b_in = b; cin_in = cin; sub_in = sub;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check_val("busy_run", {31'd0, busy}, 32'd1);
    check_val("ready_run", {31'd0, start_ready}, 32'd0);
    lat = 0;
    while (!done_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("latency", lat, NIB);
    check_val("sum", {16'd0, sum_o}, {16'd0, es});
    check_val("cout", {31'd0, cout_o}, {31'd0, ec});
    check_val("v", {31'd0, v_o}, {31'd0, ev});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_val("hold_valid", {31'd0, done_valid}, 32'd1);
      check_val("hold_sum", {16'd0, sum_o}, {16'd0, es});
    end
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check_val("done_clr", {31'd0, done_valid}, 32'd0);
    check_val("ready_back", {31'd0, start_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] es;
    logic         ec, ev;
    int           lat;

    #12;
    check_val("rst_sum", {16'd0, sum_o}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_ready", {31'd0, start_ready}, 32'd1);
    check_val("rst_cout", {31'd0, cout_o}, 32'd0);
    check_val("rst_v", {31'd0, v_o}, 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 2);

    // Backpressure: result frozen, new requests ignored while DONE.
    run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0);
    wait_idle();
    model(16'h2222, 16'h3333, 1'b0, 1'b0, es, ec, ev);
    @(negedge clk);
    start_valid = 1'b1;
    a_in = 16'h2222; b_in = 16'h3333; cin_in = 1'b0; sub_in = 1'b0;
    @(posedge clk); #1;
    repeat (NIB) @(posedge clk);
    #1;
    check_val("bp_valid", {31'd0, done_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_in = W'($urandom); b_in = W'($urandom); sub_in = 1'($urandom);
      @(posedge clk); #1;
      check_val("bp_sum", {16'd0, sum_o}, {16'd0, es});
      check_val("bp_cout", {31'd0, cout_o}, {31'd0, ec});
      check_val("bp_v", {31'd0, v_o}, {31'd0, ev});
      check_val("bp_ready", {31'd0, start_ready}, 32'd0);
    end
    @(negedge clk);
    a_in = 16'hA5A5; b_in = 16'h0F0F; cin_in = 1'b1; sub_in = 1'b1;
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    check_val("bp_idle", {31'd0, start_ready}, 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check_val("bp_accept", {31'd0, busy}, 32'd1);
    model(16'hA5A5, 16'h0F0F, 1'b1, 1'b1, es, ec, ev);
    lat = 0;
    while (!done_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("bp_lat", lat, NIB);
    check_val("bp_new_sum", {16'd0, sum_o}, {16'd0, es});
    check_val("bp_new_cout", {31'd0, cout_o}, {31'd0, ec});
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;

    // Asynchronous reset after two nibble steps.
    wait_idle();
    @(negedge clk);
    start_valid = 1'b1;
    a_in = 16'hABCD; b_in = 16'h1111; cin_in = 1'b1; sub_in = 1'b0;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("ar_sum", {16'd0, sum_o}, 32'd0);
    check_val("ar_cout", {31'd0, cout_o}, 32'd0);
    check_val("ar_v", {31'd0, v_o}, 32'd0);
    check_val("ar_done", {31'd0, done_valid}, 32'd0);
    check_val("ar_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("ar_ready", {31'd0, start_ready}, 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_serial_ctrl.md
Name: adder_serial_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit ripple-carry adder slice, the team's existing 4-bit bus adder. It processes one nibble per clock, LSB first, and holds the inter-nibble carry in a register. Operands are accepted through a valid/ready request port, and the result is returned through a valid/ready response port. It sits between the wide-operand datapath and the shared 4-bit adder hardware.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8 (elaboration error otherwise)
NIB, WIDTH/4, derived localparam; number of nibble steps per operation

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request valid; A, B, Cin, Sub qualified by it
start_ready  output  1  controller can accept a request
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Cin  input  1  carry-in for add; ignored when Sub=1
Sub  input  1  1 = compute A - B (A + ~B + 1)
Sum  output  WIDTH  result, valid while done_valid=1
Cout  output  1  carry out of MSB nibble (for Sub: 1 = no borrow)
V  output  1  signed overflow of the WIDTH-bit operation
done_valid  output  1  result available
done_ready  input  1  consumer accepts result
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0, asynchronous, any state): FSM to IDLE, nibble counter=0, carry reg=0. Outputs: Sum=0, Cout=0, V=0, done_valid=0, busy=0, start_ready=1 after reset release. An in-flight operation is discarded; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready=1. On start_valid=1 at an edge:
  - latch opA=A and opB=(Sub ? ~B : B);
  - carry reg = Sub ? 1 : Cin;
  - counter = 0; go to RUN.
- RUN: start_ready=0. Each cycle the adder slice adds opA[3:0], opB[3:0] and carry reg. At the edge:
  - the 4-bit result shifts into Sum from the top (Sum <= {result, Sum[WIDTH-1:4]});
  - opA and opB shift right by 4; carry reg <= slice Cout;
  - counter increments.
  - When counter==NIB-1 at the edge: capture Cout = slice Cout and V = (opA[3]==opB[3]) && (result[3]!=opA[3]) for the final nibble; go to DONE.
- DONE: done_valid=1. Sum, Cout and V are held stable. start_valid is ignored (start_ready=0). On done_ready=1 at an edge: go to IDLE, done_valid=0. Sum/Cout/V keep their last values until overwritten by the next operation.
- Latency: request accepted at edge E; done_valid=1 immediately after edge E+NIB. Minimum issue interval is NIB+2 cycles: accept, NIB steps, handshake out.
- start_valid during RUN or DONE has no effect; the requester must hold its request until start_ready=1.
- done_ready held low indefinitely: stays in DONE with outputs frozen.
- Arithmetic is modulo 2^WIDTH. Cout and V are both reported and never saturate.
- busy = (state != IDLE). start_ready = (state == IDLE). Both are registered-state decodes with no combinational path from inputs.

Test Plan:
- WIDTH=16, A=0x1234, B=0x4321, Cin=0, Sub=0 -> done_valid 4 cycles after accept; Sum=0x5555, Cout=0, V=0.
- A=0xFFFF, B=0x0001, Cin=0 -> carry ripples across all 4 nibble steps; Sum=0x0000, Cout=1, V=0. Repeat with A=0xFFFF, B=0x0000, Cin=1 -> same result.
- Sub=1, A=0x0005, B=0x0007, Cin=1 (ignored) -> Sum=0xFFFE, Cout=0, V=0. Then A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, V=1, Cout=1.
- A=0x7FFF, B=0x0001 add -> Sum=0x8000, V=1, Cout=0.
- Backpressure: hold done_ready=0 for 10 cycles with start_valid=1 and changing A/B -> Sum/Cout/V constant, start_ready=0. Release done_ready -> IDLE next cycle, then the new request is accepted.
- Assert rst_n=0 asynchronously mid-RUN (after 2 nibble steps) -> all outputs 0 and start_ready=1 after release. The next request 0x0001+0x0001 yields 0x0002 with no residue from the aborted operation.
